evt_pulse_arb: RTL

EVT_PULSE_ARB -- requirements
Module: evt_pulse_arb

---
 rtl/evt_pulse_arb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/evt_pulse_arb.sv
// evt_pulse_arb: round-robin arbiter that turns level requests from four
// requesters into single issue strobes for one shared transmitter.
// Optional WAIT_DONE watchdog: define EVT_PULSE_ARB_TIMEOUT_EN.
module evt_pulse_arb #(
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] lvl_req,
  input  logic       tx_done,
  output logic       evt_pulse,
  output logic [1:0] evt_id,
  output logic       busy,
  output logic [3:0] evt_drop,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] s1, s2, rise, pending, clr_mask;
  logic [1:0] last_grant, grant_idx, evt_id_nxt, cand;
  logic       grant_vld, expire, tmo_fire;

  // Watchdog limits outside 1..255 cannot be held by the 8-bit counter.
  if (TO_CYCLES < 1 || TO_CYCLES > 255) begin : g_bad_to_cycles
    $error("evt_pulse_arb: TO_CYCLES must be within 1..255");
  end

  // Two-flop synchroniser per requester; s1 is the newer sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= lvl_req;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;

  // Round-robin pick: scan +4 down to +1 so the nearest set bit after last_grant wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant;
    cand      = last_grant;
    for (int k = 4; k >= 1; k--) begin
      cand = last_grant + 2'(k);
      if (pending[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

`ifdef EVT_PULSE_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt;

  // Watchdog counts WAIT_DONE cycles and rests at zero in every other state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state == WAIT_DONE) begin
      wd_cnt <= wd_cnt + 8'd1;
    end else begin
      wd_cnt <= '0;
    end
  end

  assign expire = (wd_cnt == 8'(TO_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  // Next-state logic; tx_done wins over a watchdog expiry in the same cycle.
  always_comb begin
    state_nxt  = state;
    evt_id_nxt = evt_id;
    clr_mask   = '0;
    tmo_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nxt  = ISSUE;
          evt_id_nxt = grant_idx;
          clr_mask   = 4'b0001 << grant_idx;
        end
      end
      ISSUE: begin
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_nxt = IDLE;
        end else if (expire) begin
          state_nxt = IDLE;
          tmo_fire  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register, served index, priority pointer and the registered issue strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      evt_id     <= 2'd0;
      last_grant <= 2'd3;
      evt_pulse  <= 1'b0;
    end else begin
      state     <= state_nxt;
      evt_id    <= evt_id_nxt;
      evt_pulse <= (state_nxt == ISSUE);
      if (state == ISSUE) begin
        last_grant <= evt_id;
      end
    end
  end

  // Pending flags: a rise on the grant edge re-arms the flag, a rise on a held flag is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      evt_drop <= '0;
    end else begin
      evt_drop <= rise & pending & ~clr_mask;
      pending  <= (pending & ~clr_mask) | rise;
    end
  end

  assign busy        = (state != IDLE);
  assign timeout_err = tmo_fire;

endmodule
